serv_ls_seq: RTL and testbench

- Sequencer for the bit-serial load/store/shift buffer register and the memory bus. It runs the instruction through its phases:
  - init (operand shift-in)
  - bus access, or shift-count wait
  - run (result shift-out)
  - completion
- It generates the init/enable/byte-count/cnt7/cnt_done timing the buffer register consumes, drives the bus request, byte selects and load strobe, and flags misaligned accesses.
- It sits between the decoder and the buffer register/bus interface.

---
 rtl/serv_ls_pkg.sv | 37 +++
 rtl/serv_ls_seq_if.sv | 10 +
 rtl/serv_ls_cnt.sv | 33 +++
 rtl/serv_ls_seq.sv | 127 ++++++++++++
 tb/tb_serv_ls_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/serv_ls_pkg.sv
// Shared types and decode helpers for the load/store/shift sequencer.
package serv_ls_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_BUS,
    ST_SHWAIT,
    ST_RUN
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size code 3 falls through to the word decode.
  function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] lsb);
    logic [3:0] sel;
    case (size)
      SZ_BYTE: sel = 4'b0001 << lsb;
      SZ_HALF: sel = lsb[1] ? 4'b1100 : 4'b0011;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lsb[0];
      default: mis = |lsb;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/serv_ls_seq_if.sv
// Memory bus handshake between the sequencer and the bus interface.
interface serv_ls_seq_if;
  logic       wb_cyc;
  logic       wb_we;
  logic [3:0] wb_sel;
  logic       wb_ack;

  modport master (output wb_cyc, output wb_we, output wb_sel, input wb_ack);
  modport slave  (input wb_cyc, input wb_we, input wb_sel, output wb_ack);
endinterface

// File: rtl/serv_ls_cnt.sv
// Bit-position counter stepping by W; one full lap is one serial phase.
module serv_ls_cnt #(
  parameter int W = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic [4:0] o_cnt,
  output logic [1:0] o_bytecnt,
  output logic       o_cnt7,
  output logic       o_cnt_done
);

  localparam logic [4:0] STEP     = 5'(W);
  localparam logic [4:0] LAST     = 5'(32 - W);
  localparam logic [2:0] LOW_LAST = 3'(8 - W);

  logic [4:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= 5'd0;
    end else if (i_en) begin
      cnt <= cnt + STEP;
    end
  end

  assign o_cnt      = cnt;
  assign o_bytecnt  = cnt[4:3];
  assign o_cnt7     = (cnt[2:0] == LOW_LAST);
  assign o_cnt_done = i_en && (cnt == LAST);

endmodule

// File: rtl/serv_ls_seq.sv
// Phase sequencer for the serial buffer register: init, bus or shift wait, run, done.
module serv_ls_seq
  import serv_ls_pkg::*;
#(
  parameter int W = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req,
  input  logic            i_mem_op,
  input  logic            i_shift_op,
  input  logic            i_we,
  input  logic [1:0]      i_size,
  input  logic [1:0]      i_lsb,
  input  logic            i_sh_done,
  serv_ls_seq_if.master   bus,
  output logic            o_ready,
  output logic            o_init,
  output logic            o_en,
  output logic [4:0]      o_cnt,
  output logic [1:0]      o_bytecnt,
  output logic            o_cnt7,
  output logic            o_cnt_done,
  output logic            o_sh_right_wait,
  output logic            o_load,
  output logic            o_misalign,
  output logic            o_done
);

  state_t     state, state_nxt;
  logic       mem_q, shift_q, we_q;
  logic [1:0] size_q, lsb_q;
  logic       in_bus;

  serv_ls_cnt #(.W(W)) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (o_en),
    .o_cnt      (o_cnt),
    .o_bytecnt  (o_bytecnt),
    .o_cnt7     (o_cnt7),
    .o_cnt_done (o_cnt_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      mem_q   <= 1'b0;
      shift_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      lsb_q   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && i_req) begin
        mem_q   <= i_mem_op;
        shift_q <= i_shift_op;
        we_q    <= i_we;
        size_q  <= i_size;
        lsb_q   <= i_lsb;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    o_ready         = 1'b0;
    o_init          = 1'b0;
    o_en            = 1'b0;
    o_sh_right_wait = 1'b0;
    o_load          = 1'b0;
    o_misalign      = 1'b0;
    o_done          = 1'b0;
    in_bus          = 1'b0;
    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_req) state_nxt = (i_mem_op || i_shift_op) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        o_init = 1'b1;
        o_en   = 1'b1;
        if (o_cnt_done) begin
          // mem_op takes priority, so a set shift_q only matters for non-memory ops
          if (mem_q && misaligned(size_q, lsb_q)) begin
            o_done     = 1'b1;
            o_misalign = 1'b1;
            state_nxt  = ST_IDLE;
          end else if (mem_q) begin
            state_nxt = ST_BUS;
          end else begin
            state_nxt = ST_SHWAIT;
          end
        end
      end
      ST_BUS: begin
        in_bus = 1'b1;
        if (bus.wb_ack) begin
          if (we_q) begin
            o_done    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            o_load    = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_SHWAIT: begin
        o_sh_right_wait = 1'b1;
        if (i_sh_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_en = 1'b1;
        if (o_cnt_done) begin
          o_done    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.wb_cyc = in_bus;
  assign bus.wb_we  = in_bus && we_q;
  assign bus.wb_sel = in_bus ? byte_sel(size_q, lsb_q) : 4'b0000;

endmodule

// File: tb/tb_serv_ls_seq.sv
// Self-checking bench for serv_ls_seq: transaction table with scoreboard, plus reset and W=4 sequences.
module tb_serv_ls_seq;

  typedef struct {
    logic       mem, sh, we;
    logic [1:0] size, lsb;
    int         ack_dly, sh_dly;
    int         e_init, e_bus, e_shw, e_run, e_load;
    logic [3:0] e_sel;
    logic       e_we, e_mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=1 instance
  logic       req = 0, mem_op = 0, shift_op = 0, we = 0, sh_done = 0;
  logic [1:0] size = 0, lsb = 0;
  logic       ready, init, en, cnt7, cnt_done, shw, load, mis, done;
  logic [4:0] cnt;
  logic [1:0] bytecnt;
  serv_ls_seq_if bus1 ();

  serv_ls_seq #(.W(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mem_op(mem_op), .i_shift_op(shift_op),
    .i_we(we), .i_size(size), .i_lsb(lsb), .i_sh_done(sh_done), .bus(bus1.master),
    .o_ready(ready), .o_init(init), .o_en(en), .o_cnt(cnt), .o_bytecnt(bytecnt),
    .o_cnt7(cnt7), .o_cnt_done(cnt_done), .o_sh_right_wait(shw), .o_load(load),
    .o_misalign(mis), .o_done(done)
  );

  // W=4 instance, used only for an ALU op
  logic       req4 = 0, z1 = 0;
  logic [1:0] z2 = 0;
  logic       ready4, init4, en4, cnt7_4, cnt_done4, shw4, load4, mis4, done4;
  logic [4:0] cnt4;
  logic [1:0] bytecnt4;
  serv_ls_seq_if bus4 ();

  serv_ls_seq #(.W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req4), .i_mem_op(z1), .i_shift_op(z1),
    .i_we(z1), .i_size(z2), .i_lsb(z2), .i_sh_done(z1), .bus(bus4.master),
    .o_ready(ready4), .o_init(init4), .o_en(en4), .o_cnt(cnt4), .o_bytecnt(bytecnt4),
    .o_cnt7(cnt7_4), .o_cnt_done(cnt_done4), .o_sh_right_wait(shw4), .o_load(load4),
    .o_misalign(mis4), .o_done(done4)
  );

  int n_total = 0, n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  vec_t sb[$];
  int   done_events = 0;
  int   n_init = 0, n_bus = 0, n_shw = 0, n_run = 0, n_load = 0;
  logic [3:0] obs_sel = 0;
  logic       obs_we = 0;

  // Monitor: accumulate per-transaction observations, compare against scoreboard at o_done
  always @(negedge clk) begin
    if (!rst_n) begin
      n_init = 0; n_bus = 0; n_shw = 0; n_run = 0; n_load = 0; obs_sel = 0; obs_we = 0;
    end else begin
      if (init) n_init++;
      if (en && !init) n_run++;
      if (shw) n_shw++;
      if (bus1.wb_cyc) begin
        n_bus++;
        obs_sel = bus1.wb_sel;
        obs_we  = bus1.wb_we;
      end
      if (load) begin
        n_load++;
        chk("load_only_on_ack", int'(bus1.wb_ack), 1);
      end
      if (done) begin
        chk("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          vec_t e;
          e = sb.pop_front();
          chk("init_cycles", n_init, e.e_init);
          chk("bus_cycles", n_bus, e.e_bus);
          chk("shwait_cycles", n_shw, e.e_shw);
          chk("run_cycles", n_run, e.e_run);
          chk("load_pulses", n_load, e.e_load);
          chk("wb_sel", int'(obs_sel), int'(e.e_sel));
          chk("wb_we", int'(obs_we), int'(e.e_we));
          chk("misalign", int'(mis), int'(e.e_mis));
          if (e.e_run > 0 || e.e_mis) begin
            chk("done_cnt", int'(cnt), 31);
            chk("done_cnt_done", int'(cnt_done), 1);
          end
        end
        n_init = 0; n_bus = 0; n_shw = 0; n_run = 0; n_load = 0; obs_sel = 0; obs_we = 0;
        done_events++;
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int d0, bc, sc;
    d0 = done_events;
    bc = 0;
    sc = 0;
    sb.push_back(v);
    req = 1; mem_op = v.mem; shift_op = v.sh; we = v.we; size = v.size; lsb = v.lsb;
    @(posedge clk); #1;
    req = 0;
    for (int c = 0; c < 300; c++) begin
      if (done_events != d0) break;
      bus1.wb_ack = bus1.wb_cyc && (bc == v.ack_dly);
      if (bus1.wb_cyc) bc++;
      sh_done = (v.sh_dly == 0) || (shw && sc >= v.sh_dly);
      if (shw) sc++;
      @(posedge clk); #1;
    end
    bus1.wb_ack = 0;
    sh_done = 0;
    chk("txn_completed", int'(done_events != d0), 1);
    chk("ready_after_done", int'(ready), 1);
    if (done_events == d0) sb.delete();
  endtask

  vec_t tbl[12];

  initial begin
    bus1.wb_ack = 0;
    bus4.wb_ack = 0;
    //          mem sh we size  lsb  ack sh  init bus shw run load sel   we mis
    tbl[0]  = '{1, 0, 1, 2'd2, 2'd0, 3, 0, 32, 4, 0, 0,  0, 4'hF, 1, 0};
    tbl[1]  = '{1, 0, 0, 2'd0, 2'd3, 1, 0, 32, 2, 0, 32, 1, 4'h8, 0, 0};
    tbl[2]  = '{1, 0, 0, 2'd1, 2'd1, 0, 0, 32, 0, 0, 0,  0, 4'h0, 0, 1};
    tbl[3]  = '{0, 1, 0, 2'd0, 2'd0, 0, 5, 32, 0, 6, 32, 0, 4'h0, 0, 0};
    tbl[4]  = '{0, 1, 0, 2'd0, 2'd0, 0, 0, 32, 0, 1, 32, 0, 4'h0, 0, 0};
    tbl[5]  = '{0, 0, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 32, 0, 4'h0, 0, 0};
    tbl[6]  = '{1, 0, 1, 2'd1, 2'd2, 0, 0, 32, 1, 0, 0,  0, 4'hC, 1, 0};
    tbl[7]  = '{1, 0, 0, 2'd2, 2'd2, 0, 0, 32, 0, 0, 0,  0, 4'h0, 0, 1};
    tbl[8]  = '{1, 0, 1, 2'd0, 2'd1, 2, 0, 32, 3, 0, 0,  0, 4'h2, 1, 0};
    tbl[9]  = '{1, 0, 0, 2'd3, 2'd0, 0, 0, 32, 1, 0, 32, 1, 4'hF, 0, 0};
    tbl[10] = '{1, 1, 0, 2'd1, 2'd0, 1, 0, 32, 2, 0, 32, 1, 4'h3, 0, 0};
    tbl[11] = '{1, 0, 1, 2'd1, 2'd3, 0, 0, 32, 0, 0, 0,  0, 4'h0, 0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_cyc", int'(bus1.wb_cyc), 0);
    chk("rst_sel", int'(bus1.wb_sel), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_ready4", int'(ready4), 1);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_txn(tbl[i]);

    // Reset asserted mid-BUS; a late ack must be ignored
    req = 1; mem_op = 1; shift_op = 0; we = 0; size = 2'd0; lsb = 2'd0;
    @(posedge clk); #1;
    req = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus1.wb_cyc) break;
      @(posedge clk); #1;
    end
    chk("abort_reached_bus", int'(bus1.wb_cyc), 1);
    begin
      int d0;
      d0 = done_events;
      rst_n = 0;
      #1;
      chk("abort_cyc_async", int'(bus1.wb_cyc), 0);
      chk("abort_ready", int'(ready), 1);
      chk("abort_cnt", int'(cnt), 0);
      @(posedge clk); #1;
      rst_n = 1;
      bus1.wb_ack = 1;
      @(negedge clk);
      chk("late_ack_load", int'(load), 0);
      chk("late_ack_done", int'(done), 0);
      chk("late_ack_cyc", int'(bus1.wb_cyc), 0);
      @(posedge clk); #1;
      bus1.wb_ack = 0;
      chk("late_ack_no_done_event", done_events - d0, 0);
    end

    // W=4 ALU op: 8 run cycles, counter steps by 4
    req4 = 1;
    @(posedge clk); #1;
    req4 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("w4_cnt", int'(cnt4), 4 * i);
      chk("w4_bytecnt", int'(bytecnt4), (4 * i) / 8);
      chk("w4_cnt7", int'(cnt7_4), int'(((4 * i) % 8) == 4));
      chk("w4_en", int'(en4), 1);
      chk("w4_done", int'(done4), int'(i == 7));
    end
    @(negedge clk);
    chk("w4_ready_after", int'(ready4), 1);
    chk("w4_cnt_wrapped", int'(cnt4), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
